// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS core: load/store over a req/ack bus, write-back select, MEM_WB register.
// Define MEM_TIMEOUT_EN to force-complete accesses left unacknowledged for TIMEOUT request cycles.
module mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic         clk,
    input  logic         reset_b,
    input  logic [138:0] EX_MEM,
    input  logic         IRQ_BACKUP,
    input  logic         IRQ_RECOVERY,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic [31:0]  mem_rdata,
    input  logic         mem_ack,
    output logic         stall,
    output logic         bus_err,
    output logic [37:0]  MEM_WB,
    output logic         o_dbg_state
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t      r_state;
    logic [37:0] r_mem_wb;
    logic [37:0] r_shadow;

    logic [31:0] w_wdata;
    logic [31:0] w_alu;
    logic [4:0]  w_wreg;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_reg_write;
    logic [1:0]  w_mem_to_reg;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_lu_data;
    logic        w_lu_op;
    logic        w_memop;
    logic        w_force_done;
    logic [31:0] w_load_data;
    logic [31:0] w_wb_data;
    logic        w_irq_ok;

    assign w_wdata      = EX_MEM[31:0];
    assign w_alu        = EX_MEM[63:32];
    assign w_wreg       = EX_MEM[68:64];
    assign w_mem_read   = EX_MEM[69];
    assign w_mem_write  = EX_MEM[70];
    assign w_reg_write  = EX_MEM[71];
    assign w_mem_to_reg = EX_MEM[73:72];
    assign w_pc_plus4   = EX_MEM[105:74];
    assign w_lu_data    = EX_MEM[137:106];
    assign w_lu_op      = EX_MEM[138];

    assign w_memop   = w_mem_read | w_mem_write;
    assign mem_req   = w_memop;
    assign mem_we    = w_mem_write;
    assign mem_addr  = {w_alu[31:2], 2'b00};
    assign mem_wdata = w_wdata;

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_err;

    // r_cnt counts WAIT cycles; the first request cycle is spent in IDLE,
    // so TIMEOUT-2 in WAIT is the TIMEOUT-th cycle with mem_req high.
    assign w_force_done = (r_state == S_WAIT) && !mem_ack &&
                          (r_cnt == CNT_W'(TIMEOUT - 2));
    assign bus_err      = r_bus_err;
`else
    logic [31:0] w_unused_cfg;

    assign w_unused_cfg = 32'(TIMEOUT + CNT_W);
    assign w_force_done = 1'b0;
    assign bus_err      = 1'b0;
`endif

    assign stall       = w_memop & ~mem_ack & ~w_force_done;
    assign w_load_data = w_force_done ? 32'b0 : mem_rdata;
    assign w_irq_ok    = (r_state == S_IDLE) && !stall;

    assign w_wb_data = w_lu_op               ? w_lu_data   :
                       (w_mem_to_reg == 2'b01) ? w_load_data :
                       (w_mem_to_reg == 2'b10) ? w_pc_plus4  : w_alu;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state   <= S_IDLE;
            r_mem_wb  <= 38'b0;
            r_shadow  <= 38'b0;
`ifdef MEM_TIMEOUT_EN
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_memop && !mem_ack) begin
                        r_state <= S_WAIT;
`ifdef MEM_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (mem_ack || w_force_done) begin
                        r_state <= S_IDLE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase

            // Bubble while stalled so write-back never repeats an instruction.
            if (stall) begin
                r_mem_wb <= 38'b0;
            end else if (w_irq_ok && IRQ_RECOVERY) begin
                r_mem_wb <= r_shadow;
            end else if (w_irq_ok && IRQ_BACKUP) begin
                r_shadow <= r_mem_wb;
                r_mem_wb <= 38'b0;
            end else begin
                r_mem_wb <= {w_reg_write, w_wreg, w_wb_data};
            end

`ifdef MEM_TIMEOUT_EN
            r_bus_err <= w_force_done;
`endif
        end
    end

    assign MEM_WB      = r_mem_wb;
    assign o_dbg_state = (r_state == S_WAIT);

endmodule
